// File: rtl/maquina_de_lavar_planta_if.sv
// Command/sensor bundle between the washing machine controller (master) and its plant (slave).
// The controller drives one-hot actuator commands; the plant answers with sensor levels.
interface maquina_de_lavar_planta_if #(
  parameter int LARGURA = 8
);
  logic               valvula_agua;
  logic               modo_agitar;
  logic               modo_girar;
  logic               cheio;
  logic               tempo;
  logic               secar;
  logic [LARGURA-1:0] nivel;
  logic [2:0]         estado_planta;
  logic               erro;

  modport master (
    output valvula_agua, modo_agitar, modo_girar,
    input  cheio, tempo, secar, nivel, estado_planta, erro
  );

  modport slave (
    input  valvula_agua, modo_agitar, modo_girar,
    output cheio, tempo, secar, nivel, estado_planta, erro
  );
endinterface

// File: rtl/maquina_de_lavar_planta.sv
// Washing machine plant model: tank level, agitation and spin timers driven by one-hot commands.
// Commands act on the same edge; sensors are decoded from registers only; no backpressure.
module maquina_de_lavar_planta #(
  parameter int LARGURA      = 8,
  parameter int NIVEL_CHEIO  = 20,
  parameter int TEMPO_AGITAR = 10,
  parameter int TEMPO_GIRAR  = 6,
  parameter int DRENO        = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  maquina_de_lavar_planta_if.slave   bus
);

  typedef enum logic [2:0] {
    PARADO        = 3'd0,
    ENCHENDO      = 3'd1,
    AGITANDO      = 3'd2,
    CENTRIFUGANDO = 3'd3,
    ERRO          = 3'd4
  } estado_t;

  localparam logic [LARGURA-1:0] UM     = LARGURA'(1);
  localparam logic [LARGURA-1:0] ZERO   = '0;
  localparam logic [LARGURA-1:0] CHEIO  = LARGURA'(NIVEL_CHEIO);
  localparam logic [LARGURA-1:0] T_AGIT = LARGURA'(TEMPO_AGITAR);
  localparam logic [LARGURA-1:0] T_GIRO = LARGURA'(TEMPO_GIRAR);
  localparam logic [LARGURA-1:0] DRN    = LARGURA'(DRENO);

  estado_t            estado, estado_n;
  logic [LARGURA-1:0] nivel, nivel_n;
  logic [LARGURA-1:0] cont_agitar, cont_agitar_n;
  logic [LARGURA-1:0] cont_girar, cont_girar_n;
  logic               conflito;
  logic               em_erro;

  assign conflito = (bus.valvula_agua & bus.modo_agitar) |
                    (bus.valvula_agua & bus.modo_girar)  |
                    (bus.modo_agitar  & bus.modo_girar);
  assign em_erro  = (estado == ERRO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= PARADO;
      nivel       <= ZERO;
      cont_agitar <= ZERO;
      cont_girar  <= ZERO;
    end else begin
      estado      <= estado_n;
      nivel       <= nivel_n;
      cont_agitar <= cont_agitar_n;
      cont_girar  <= cont_girar_n;
    end
  end

  // An illegal command freezes level and timers exactly as they were.
  always_comb begin
    estado_n      = estado;
    nivel_n       = nivel;
    cont_agitar_n = cont_agitar;
    cont_girar_n  = cont_girar;
    if (em_erro || conflito) begin
      estado_n = ERRO;
    end else if (bus.valvula_agua) begin
      estado_n      = ENCHENDO;
      cont_agitar_n = ZERO;
      cont_girar_n  = ZERO;
      if (nivel < CHEIO) nivel_n = nivel + UM;
    end else if (bus.modo_agitar) begin
      estado_n     = AGITANDO;
      cont_girar_n = ZERO;
      if (cont_agitar < T_AGIT) cont_agitar_n = cont_agitar + UM;
    end else if (bus.modo_girar) begin
      estado_n      = CENTRIFUGANDO;
      cont_agitar_n = ZERO;
      nivel_n       = (nivel < DRN) ? ZERO : nivel - DRN;
      if (cont_girar < T_GIRO) cont_girar_n = cont_girar + UM;
    end else begin
      estado_n      = PARADO;
      cont_agitar_n = ZERO;
      cont_girar_n  = ZERO;
    end
  end

  assign bus.nivel         = nivel;
  assign bus.estado_planta = estado;
  assign bus.erro          = em_erro;
  assign bus.cheio         = (nivel >= CHEIO) && !em_erro;
  assign bus.tempo         = (cont_agitar == T_AGIT) && !em_erro;
  assign bus.secar         = (estado == CENTRIFUGANDO) &&
                             ((nivel != ZERO) || (cont_girar < T_GIRO));

endmodule

// File: tb/tb_maquina_de_lavar_planta.sv
// Bench for the washing machine plant: fixed vector table, async-reset corner and random
// command streams compared against a level/timer reference model.
module tb_maquina_de_lavar_planta;

  localparam int NC = 20;
  localparam int TA = 10;
  localparam int TG = 6;
  localparam int DR = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  maquina_de_lavar_planta_if #(.LARGURA(8)) intf ();

  maquina_de_lavar_planta #(
    .LARGURA(8), .NIVEL_CHEIO(NC), .TEMPO_AGITAR(TA), .TEMPO_GIRAR(TG), .DRENO(DR)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (intf.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: level and timers as plain integers.
  int m_lvl, m_ca, m_cg, m_st;

  typedef struct {
    bit v, a, g;
    int reps;
    int nivel;
    bit cheio, tempo, secar;
    int est;
    bit erro;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_ca = 0; m_cg = 0; m_st = 0;
  endtask

  task automatic model_edge(input bit v, input bit a, input bit g);
    int n;
    n = int'(v) + int'(a) + int'(g);
    if (m_st == 4 || n > 1) begin
      m_st = 4;
    end else if (n == 0) begin
      m_st = 0; m_ca = 0; m_cg = 0;
    end else if (v) begin
      m_st = 1; m_lvl = imin(m_lvl + 1, NC); m_ca = 0; m_cg = 0;
    end else if (a) begin
      m_st = 2; m_ca = imin(m_ca + 1, TA); m_cg = 0;
    end else begin
      m_st = 3; m_lvl = imax(m_lvl - DR, 0); m_cg = imin(m_cg + 1, TG); m_ca = 0;
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {intf.nivel, intf.cheio, intf.tempo, intf.secar, intf.estado_planta, intf.erro};
  endfunction

  function automatic logic [15:0] model_vec();
    logic [7:0] lv;
    logic [2:0] st;
    logic ch, tp, sc, er;
    lv = 8'(m_lvl);
    st = 3'(m_st);
    er = (m_st == 4);
    ch = (m_lvl >= NC) && !er;
    tp = (m_ca == TA) && !er;
    sc = (m_st == 3) && (m_lvl != 0 || m_cg < TG);
    return {lv, ch, tp, sc, st, er};
  endfunction

  task automatic step(input bit v, input bit a, input bit g);
    @(negedge clock);
    intf.valvula_agua = v;
    intf.modo_agitar  = a;
    intf.modo_girar   = g;
    @(posedge clock);
    #1;
    model_edge(v, a, g);
    chk("model", int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    intf.valvula_agua = 1'b0;
    intf.modo_agitar  = 1'b0;
    intf.modo_girar   = 1'b0;
    #2;
    model_reset();
    chk("reset_state", int'(dut_vec()), 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    //            v  a  g reps nivel ch tp sc est er
    tbl[0]  = '{1, 0, 0, 19, 19, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 1,  20, 1, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 5,  20, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 9,  20, 1, 0, 0, 2, 0};
    tbl[4]  = '{0, 1, 0, 1,  20, 1, 1, 0, 2, 0};
    tbl[5]  = '{0, 1, 0, 3,  20, 1, 1, 0, 2, 0};
    tbl[6]  = '{0, 0, 0, 1,  20, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1,  18, 0, 0, 1, 3, 0};
    tbl[8]  = '{0, 0, 1, 8,  2,  0, 0, 1, 3, 0};
    tbl[9]  = '{0, 0, 1, 1,  0,  0, 0, 0, 3, 0};
    tbl[10] = '{0, 0, 1, 2,  0,  0, 0, 0, 3, 0};
    tbl[11] = '{1, 0, 0, 5,  5,  0, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 2,  1,  0, 0, 1, 3, 0};
    tbl[13] = '{0, 0, 1, 1,  0,  0, 0, 1, 3, 0};
    tbl[14] = '{0, 0, 1, 2,  0,  0, 0, 1, 3, 0};
    tbl[15] = '{0, 0, 1, 1,  0,  0, 0, 0, 3, 0};
    tbl[16] = '{1, 0, 1, 1,  0,  0, 0, 0, 4, 1};
    tbl[17] = '{0, 0, 0, 3,  0,  0, 0, 0, 4, 1};

    intf.valvula_agua = 1'b0;
    intf.modo_agitar  = 1'b0;
    intf.modo_girar   = 1'b0;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].v, tbl[i].a, tbl[i].g);
      chk($sformatf("vec%0d_nivel", i), int'(intf.nivel), tbl[i].nivel);
      chk($sformatf("vec%0d_cheio", i), int'(intf.cheio), int'(tbl[i].cheio));
      chk($sformatf("vec%0d_tempo", i), int'(intf.tempo), int'(tbl[i].tempo));
      chk($sformatf("vec%0d_secar", i), int'(intf.secar), int'(tbl[i].secar));
      chk($sformatf("vec%0d_estado", i), int'(intf.estado_planta), tbl[i].est);
      chk($sformatf("vec%0d_erro", i), int'(intf.erro), int'(tbl[i].erro));
    end

    // Error with a non-zero level keeps the level frozen.
    do_reset();
    for (int r = 0; r < 7; r++) step(1, 0, 0);
    step(0, 1, 1);
    chk("erro_nivel_held", int'(intf.nivel), 7);
    step(0, 0, 1);
    chk("erro_sticky_nivel", int'(intf.nivel), 7);
    chk("erro_sticky_flag", int'(intf.erro), 1);

    // Async reset mid-agitation at nivel=20, cont_agitar=7.
    do_reset();
    for (int r = 0; r < 20; r++) step(1, 0, 0);
    for (int r = 0; r < 7; r++) step(0, 1, 0);
    chk("pre_async_nivel", int'(intf.nivel), 20);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(dut_vec()), 0);
    model_reset();
    intf.modo_agitar = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 1, 0);
    chk("after_async_tempo", int'(intf.tempo), 0);

    // Random command runs against the reference model.
    for (int round = 0; round < 4; round++) begin
      int cyc;
      do_reset();
      cyc = 0;
      while (cyc < 300) begin
        int sel, len;
        bit v, a, g;
        sel = $urandom_range(0, 19);
        len = $urandom_range(1, 25);
        v = 0; a = 0; g = 0;
        if (sel == 0) begin
          v = 1'($urandom_range(0, 1));
          a = 1'b1;
          g = !v;
          len = 1;
        end else if (sel < 4) begin
          len = $urandom_range(1, 3);
        end else if (sel < 9) begin
          v = 1'b1;
        end else if (sel < 13) begin
          a = 1'b1;
        end else begin
          g = 1'b1;
        end
        for (int r = 0; r < len; r++) step(v, a, g);
        cyc += len;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
